mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word store with a zero-fill start-up phase and a
// small memory-mapped I/O window (switch input, LED register, write counter).
module mem_responder #(
   parameter int                ADDR_W  = 12,
   parameter int                DATA_W  = 16,
   parameter logic [ADDR_W-1:0] IO_BASE = 12'hFF0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_data,
   input  logic              m_rw,
   output logic [DATA_W-1:0] m_q,
   output logic              ready,
   input  logic [DATA_W-1:0] sw_in,
   output logic [DATA_W-1:0] led_out
);

   localparam logic [0:0]        ST_INIT  = 1'b0;
   localparam logic [0:0]        ST_READY = 1'b1;
   localparam logic [1:0]        SEL_ZERO = 2'd0;
   localparam logic [1:0]        SEL_MEM  = 2'd1;
   localparam logic [1:0]        SEL_IO   = 2'd2;
   localparam logic [ADDR_W-1:0] CLR_LAST = '1;
   localparam logic [ADDR_W-1:0] IO_SPAN  = ADDR_W'(16);

   logic [DATA_W-1:0] mem_array [2**ADDR_W];
   logic [DATA_W-1:0] mem_rd_q;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [1:0]        sel_q, sel_d;
   logic [DATA_W-1:0] io_rd_q, io_rd_d;
   logic [DATA_W-1:0] led_q, led_d;
   logic [15:0]       wcnt_q, wcnt_d;
   logic [DATA_W-1:0] sync1_q, sync2_q;

   logic [ADDR_W-1:0] io_off;
   logic              in_io;
   logic              is_ready;
   logic              arr_wr;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Address decode and array write-port steering (clear counter during INIT).
   always_comb begin
      is_ready  = (state_q == ST_READY);
      io_off    = m_addr - IO_BASE;
      in_io     = (m_addr >= IO_BASE) && (io_off < IO_SPAN);
      arr_wr    = is_ready && m_rw && !in_io;
      // Held off while reset is low so the array is only touched by real cycles.
      mem_we    = reset && (arr_wr || !is_ready);
      mem_waddr = is_ready ? m_addr : clr_cnt_q;
      mem_wdata = is_ready ? m_data : '0;
   end

   // INIT walks the clear counter across every word, then parks in READY.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (!is_ready) begin
         clr_cnt_d = clr_cnt_q + ADDR_W'(1);
         if (clr_cnt_q == CLR_LAST) begin
            state_d = ST_READY;
         end
      end
   end

   // Access decode: picks the read-data source and updates the I/O registers.
   always_comb begin
      sel_d   = SEL_ZERO;
      io_rd_d = '0;
      led_d   = led_q;
      wcnt_d  = wcnt_q;
      if (is_ready) begin
         if (!in_io) begin
            sel_d = SEL_MEM;
            if (m_rw) begin
               wcnt_d = wcnt_q + 16'd1;
            end
         end else begin
            sel_d = SEL_IO;
            case (io_off[3:0])
               4'd0: begin
                  if (!m_rw) io_rd_d = sync2_q;
               end
               4'd1: begin
                  if (m_rw) begin
                     led_d   = m_data;
                     io_rd_d = m_data;
                  end else begin
                     io_rd_d = led_q;
                  end
               end
               4'd2: begin
                  // A write clears the counter and is not itself counted.
                  if (m_rw) wcnt_d = '0;
                  else      io_rd_d = DATA_W'(wcnt_q);
               end
               default: io_rd_d = '0;
            endcase
         end
      end
   end

   // Storage array with registered, write-first read port; no reset so it maps to block RAM.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_array[mem_waddr] <= mem_wdata;
      end
      if (arr_wr) begin
         mem_rd_q <= m_data;
      end else begin
         mem_rd_q <= mem_array[m_addr];
      end
   end

   // Control state, I/O registers and read-source select.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_INIT;
         clr_cnt_q <= '0;
         sel_q     <= SEL_ZERO;
         io_rd_q   <= '0;
         led_q     <= '0;
         wcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         sel_q     <= sel_d;
         io_rd_q   <= io_rd_d;
         led_q     <= led_d;
         wcnt_q    <= wcnt_d;
      end
   end

   // Two-flop synchronizer for the asynchronous switch inputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw_in;
         sync2_q <= sync1_q;
      end
   end

   // Read data comes straight from registers; the select forces 0 in INIT and reset.
   always_comb begin
      case (sel_q)
         SEL_MEM: m_q = mem_rd_q;
         SEL_IO:  m_q = io_rd_q;
         default: m_q = '0;
      endcase
   end

   assign ready   = is_ready;
   assign led_out = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder with hand-computed expectations.
module tb_mem_responder;

   logic        clock;
   logic        reset;
   logic [11:0] m_addr;
   logic [15:0] m_data;
   logic        m_rw;
   logic [15:0] m_q;
   logic        ready;
   logic [15:0] sw_in;
   logic [15:0] led_out;

   int checks = 0;
   int errors = 0;

   mem_responder dut (
      .clock   (clock),
      .reset   (reset),
      .m_addr  (m_addr),
      .m_data  (m_data),
      .m_rw    (m_rw),
      .m_q     (m_q),
      .ready   (ready),
      .sw_in   (sw_in),
      .led_out (led_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s value %h", tag, obs);
      end
   endtask

   // One access: drive on the falling edge, sampled by the next rising edge, m_q read 1ns later.
   task automatic access(input logic rw, input logic [11:0] a, input logic [15:0] d,
                         output logic [15:0] q);
      @(negedge clock);
      m_rw   = rw;
      m_addr = a;
      m_data = d;
      @(posedge clock);
      #1;
      q    = m_q;
      m_rw = 1'b0;
   endtask

   // Counts rising edges after release until ready is seen high (bounded).
   task automatic wait_ready(output int n);
      n = 0;
      for (int i = 1; i <= 5000; i++) begin
         @(posedge clock);
         #1;
         if (ready) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      logic [15:0] q;
      int          n;

      reset  = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_rw   = 1'b0;
      sw_in  = '0;
      #3;
      check("rst_ready", ready, 0);
      check("rst_mq", m_q, 0);
      check("rst_led", led_out, 0);

      // Release with a write to 0x010 held throughout INIT; it must be ignored.
      @(negedge clock);
      m_rw   = 1'b1;
      m_addr = 12'h010;
      m_data = 16'hDEAD;
      reset  = 1'b1;
      n = 0;
      for (int i = 1; i <= 5000; i++) begin
         @(posedge clock);
         #1;
         if (i == 2000) check("init_mq", m_q, 0);
         if (ready) begin
            n = i;
            break;
         end
      end
      m_rw = 1'b0;
      check("init_len", n, 4096);

      access(0, 12'h000, 16'h0, q); check("rd_000", q, 16'h0000);
      access(0, 12'h7FF, 16'h0, q); check("rd_7ff", q, 16'h0000);
      access(0, 12'hFEF, 16'h0, q); check("rd_fef", q, 16'h0000);
      access(0, 12'h010, 16'h0, q); check("rd_010_after_init_wr", q, 16'h0000);
      access(0, 12'hFF2, 16'h0, q); check("wcnt_after_init", q, 16'h0000);

      // Write-first and back-to-back write/read.
      access(1, 12'h123, 16'hBEEF, q); check("wr_123_mq", q, 16'hBEEF);
      access(0, 12'h123, 16'h0, q);    check("rd_123", q, 16'hBEEF);
      access(0, 12'h124, 16'h0, q);    check("rd_124", q, 16'h0000);
      access(0, 12'hFF2, 16'h0, q);    check("wcnt_one", q, 16'h0001);

      // LED register and switch synchronizer.
      access(1, 12'hFF1, 16'h00A5, q); check("wr_led_mq", q, 16'h00A5);
      check("led_out", led_out, 16'h00A5);
      access(0, 12'hFF1, 16'h0, q);    check("rd_led", q, 16'h00A5);
      @(negedge clock);
      sw_in = 16'h1234;
      repeat (3) @(negedge clock);
      access(0, 12'hFF0, 16'h0, q);    check("rd_sw", q, 16'h1234);

      // Write counter: clear, five array writes, clear again, unused I/O words.
      access(1, 12'hFF2, 16'hFFFF, q);
      for (int i = 0; i < 5; i++) begin
         access(1, 12'h200 + 12'(i), 16'h1000 + 16'(i), q);
      end
      access(0, 12'hFF2, 16'h0, q);    check("wcnt_five", q, 16'h0005);
      access(0, 12'h203, 16'h0, q);    check("rd_203", q, 16'h1003);
      access(1, 12'hFF2, 16'h0, q);
      access(0, 12'hFF2, 16'h0, q);    check("wcnt_cleared", q, 16'h0000);
      access(1, 12'hFF5, 16'h5555, q); check("wr_ff5_mq", q, 16'h0000);
      access(0, 12'hFF5, 16'h0, q);    check("rd_ff5", q, 16'h0000);
      access(0, 12'hFF2, 16'h0, q);    check("wcnt_unchanged", q, 16'h0000);
      access(0, 12'h123, 16'h0, q);    check("rd_123_pre_rst", q, 16'hBEEF);

      // Asynchronous reset in READY, between clock edges.
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("rrst_ready", ready, 0);
      check("rrst_mq", m_q, 0);
      check("rrst_led", led_out, 0);

      // Reset again at INIT count 100.
      @(negedge clock);
      reset = 1'b1;
      repeat (100) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("irst_ready", ready, 0);
      check("irst_mq", m_q, 0);

      @(negedge clock);
      reset = 1'b1;
      wait_ready(n);
      check("reinit_len", n, 4096);
      access(0, 12'h123, 16'h0, q);    check("rd_123_after_rst", q, 16'h0000);
      access(0, 12'h200, 16'h0, q);    check("rd_200_after_rst", q, 16'h0000);
      access(0, 12'hFF1, 16'h0, q);    check("rd_led_after_rst", q, 16'h0000);
      access(0, 12'hFF2, 16'h0, q);    check("wcnt_after_rst", q, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
